reed_conditioner: RTL and testbench
===================================

Name: reed_conditioner

Overview:
Front-end for the reed-switch input of the bicycle computer. It synchronises and debounces the raw, asynchronous reed contact and emits one clean single-cycle pulse per wheel revolution. It also measures the revolution period in clock cycles and flags when the wheel has stopped. It sits between the reed pin and the distance and speed stages, which consume its reed_pulse, period and stopped outputs.

Parameters:
DEBOUNCE_CYCLES  16  consecutive synchronised samples at the new level required to accept a transition (min 2)
CNT_WIDTH  5  width of debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES
PERIOD_WIDTH  16  width of elapsed counter and period output
STOP_TIMEOUT  4000  cycles without a revolution before stopped asserts; must satisfy STOP_TIMEOUT < 2^PERIOD_WIDTH - 1

Ports:
clock  input  1  system clock; the block uses a single clock
reset  input  1  synchronous, active-high reset
reed  input  1  raw reed contact, asynchronous, bouncy
reed_clean  output  1  debounced reed level
reed_pulse  output  1  one-cycle strobe on each accepted rising edge of reed_clean
period  output  PERIOD_WIDTH  cycles between the last two accepted revolutions; 0 when stopped
period_valid  output  1  one-cycle strobe: period has just been updated with a new measurement
stopped  output  1  high when no revolution has occurred within STOP_TIMEOUT cycles

Behaviour:
- Reset values: sync FFs 0; FSM LOW; debounce counter 0; reed_clean 0; reed_pulse 0; elapsed 0; armed 0; period 0; period_valid 0; stopped 1.
- Synchroniser: two flops, reed -> s1 -> s2. The FSM sees only s2.
- Debounce FSM has four states: LOW, RISE_CHK, HIGH, FALL_CHK.
  - LOW: if s2=1, go to RISE_CHK and set the counter to 1.
  - RISE_CHK: if s2=0, return to LOW. Otherwise increment the counter. When the counter equals DEBOUNCE_CYCLES, go to HIGH, set reed_clean=1 and assert reed_pulse for exactly one cycle.
  - HIGH: if s2=0, go to FALL_CHK and set the counter to 1.
  - FALL_CHK: this is the mirror of RISE_CHK. On acceptance, go to LOW and set reed_clean=0. No pulse is generated. If s2=1 before acceptance, return to HIGH.
- Latency: with reed stable high and first sampled into s1 at edge E0, reed_pulse is high in the cycle following edge E0+DEBOUNCE_CYCLES+1. A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces no change.
- elapsed counter:
  - Increments by 1 each cycle while armed=1.
  - On a reed_pulse cycle it reloads to 1.
  - It never saturates, because the timeout occurs first.
- On a reed_pulse cycle:
  - armed=0: set armed=1 and clear stopped at the next edge. No period_valid.
  - armed=1: at the next edge, period <= elapsed and period_valid=1 for one cycle. Consequently, pulses at cycles t1 and t2 yield period = t2 - t1.
- Timeout: when armed=1, elapsed == STOP_TIMEOUT and reed_pulse=0 in the same cycle, then at the next edge stopped=1, armed=0, period=0 and elapsed=0. period_valid is not asserted on timeout.
- Simultaneous pulse and timeout in the same cycle: the pulse wins, the period is recorded and stopped stays 0.
- Reset mid-debounce or mid-measurement: all state returns to reset values at that edge. If reed is held high through reset, a full debounce occurs afterwards and produces one pulse, which only arms the period measurement.
- period holds its value between updates. period_valid and reed_pulse are never high for two consecutive cycles.

Test Plan:
(Parameters for all scenarios: DEBOUNCE_CYCLES=4, PERIOD_WIDTH=8, STOP_TIMEOUT=100.)
- Reset: assert reset for 3 cycles with reed=0 -> outputs reed_clean=0, reed_pulse=0, period=0, period_valid=0, stopped=1.
- Debounce latency: raise reed to a clean level, first sampled at edge E0 -> reed_pulse high for exactly one cycle after edge E0+5; reed_clean=1 from the same cycle; stopped drops one cycle later; no period_valid.
- Bounce rejection: toggle reed 1,0,1,0 with 2-cycle dwell, then hold 0 -> reed_clean stays 0 and no reed_pulse. A 3-sample low glitch while in HIGH -> reed_clean stays 1.
- Period measurement: generate clean revolutions so reed_pulse occurs at cycles 20, 60 and 90 -> period_valid at cycles 61 and 91, with period=40 and then period=30; stopped=0 throughout.
- Stop timeout: after the last pulse at cycle 90, give no further revolution -> stopped=1 and period=0 from cycle 191, period_valid stays 0. The next pulse only re-arms; the following pulse yields a valid period.
- Corner cases:
  - Arrange reed_pulse to coincide with elapsed==100 -> period=100, period_valid=1, stopped stays 0.
  - Assert reset during RISE_CHK -> no pulse is generated from the interrupted debounce.

Source files
------------

// File: rtl/reed_conditioner.sv
// reed_conditioner: sync+debounce reed (clock, reset, reed) -> reed_clean, reed_pulse, revolution period/period_valid, stopped
module reed_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH = 5,
  parameter int PERIOD_WIDTH = 16,
  parameter int STOP_TIMEOUT = 4000
) (
  input  logic clock,
  input  logic reset,
  input  logic reed,
  output logic reed_clean,
  output logic reed_pulse,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic period_valid,
  output logic stopped
);
  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_t;
  state_t state;
  logic s1, s2, armed;
  logic [CNT_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] elapsed;
  logic accept, timeout;
  assign accept = cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  assign timeout = armed && elapsed == PERIOD_WIDTH'(STOP_TIMEOUT);
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= LOW;
      cnt <= '0;
      reed_clean <= 1'b0;
      reed_pulse <= 1'b0;
    end else begin
      s1 <= reed;
      s2 <= s1;
      reed_pulse <= 1'b0;
      case (state)
        LOW: if (s2) begin
          state <= RISE_CHK;
          cnt <= CNT_WIDTH'(1);
        end
        RISE_CHK: if (!s2) state <= LOW;
        else if (accept) begin
          state <= HIGH;
          reed_clean <= 1'b1;
          reed_pulse <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HIGH: if (!s2) begin
          state <= FALL_CHK;
          cnt <= CNT_WIDTH'(1);
        end
        FALL_CHK: if (s2) state <= HIGH;
        else if (accept) begin
          state <= LOW;
          reed_clean <= 1'b0;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      elapsed <= '0;
      armed <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
      stopped <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      if (reed_pulse) begin
        elapsed <= PERIOD_WIDTH'(1);
        armed <= 1'b1;
        stopped <= 1'b0;
        if (armed) begin
          period <= elapsed;
          period_valid <= 1'b1;
        end
      end else if (timeout) begin
        stopped <= 1'b1;
        armed <= 1'b0;
        period <= '0;
        elapsed <= '0;
      end else if (armed) elapsed <= elapsed + 1'b1;
    end
  end
endmodule

// File: tb/tb_reed_conditioner.sv
// tb_reed_conditioner: directed checks of debounce, pulse timing, period measurement and stop timeout
module tb_reed_conditioner;
  logic clock = 1'b0, reset = 1'b1, reed = 1'b0;
  logic reed_clean, reed_pulse, period_valid, stopped;
  logic [7:0] period;
  int cyc = 0, b = 0, passed = 0, total = 0;
  int npulse = 0, npv = 0, consec = 0;
  logic pp = 1'b0, pvp = 1'b0;
  reed_conditioner #(
    .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .PERIOD_WIDTH(8), .STOP_TIMEOUT(100)
  ) dut (
    .clock(clock), .reset(reset), .reed(reed), .reed_clean(reed_clean),
    .reed_pulse(reed_pulse), .period(period), .period_valid(period_valid), .stopped(stopped)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (reed_pulse) npulse++;
    if (period_valid) npv++;
    if ((reed_pulse && pp) || (period_valid && pvp)) consec++;
    pp = reed_pulse;
    pvp = period_valid;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic go(input int k);
    while (cyc < b + k) @(negedge clock);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    chk("rst_clean", reed_clean, 0);
    chk("rst_pulse", reed_pulse, 0);
    chk("rst_period", period, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_stopped", stopped, 1);
    reset = 1'b0;
    b = cyc;
    go(14); reed = 1'b1;
    go(19); chk("lat_pulse_early", reed_pulse, 0); chk("lat_clean_early", reed_clean, 0);
    go(20); chk("lat_pulse", reed_pulse, 1); chk("lat_clean", reed_clean, 1); chk("lat_stopped_hold", stopped, 1);
    go(21); chk("lat_pulse_once", reed_pulse, 0); chk("lat_stopped_clr", stopped, 0); chk("lat_no_pv", period_valid, 0);
    go(30); reed = 1'b0;
    go(54); reed = 1'b1;
    go(60); chk("p1_pulse", reed_pulse, 1);
    go(61); chk("p1_pv", period_valid, 1); chk("p1_period", period, 40); chk("p1_stopped", stopped, 0);
    go(70); reed = 1'b0;
    go(84); reed = 1'b1;
    go(91); chk("p2_pv", period_valid, 1); chk("p2_period", period, 30);
    go(92); chk("p2_pv_once", period_valid, 0); chk("p2_hold", period, 30);
    go(100); reed = 1'b0;
    go(190); chk("to_before", stopped, 0); chk("to_period_before", period, 30);
    go(191); chk("to_stopped", stopped, 1); chk("to_period", period, 0); chk("to_no_pv", npv, 2);
    go(200); reed = 1'b1;
    go(202); reed = 1'b0;
    go(204); reed = 1'b1;
    go(206); reed = 1'b0;
    go(220); chk("bounce_clean", reed_clean, 0); chk("bounce_npulse", npulse, 3);
    go(224); reed = 1'b1;
    go(231); chk("rearm_stopped", stopped, 0); chk("rearm_no_pv", period_valid, 0); chk("rearm_period", period, 0);
    go(240); reed = 1'b0;
    go(243); reed = 1'b1;
    go(252); chk("glitch_clean", reed_clean, 1);
    go(255); reed = 1'b0;
    go(324); reed = 1'b1;
    go(330); chk("tie_pulse", reed_pulse, 1);
    go(331); chk("tie_pv", period_valid, 1); chk("tie_period", period, 100); chk("tie_stopped", stopped, 0);
    go(340); reed = 1'b0;
    go(380); reed = 1'b1;
    go(383); reset = 1'b1; reed = 1'b0;
    go(385); reset = 1'b0;
    go(400); chk("rstmid_npulse", npulse, 5); chk("rstmid_clean", reed_clean, 0); chk("rstmid_stopped", stopped, 1);
    go(410); reset = 1'b1; reed = 1'b1;
    go(412); reset = 1'b0;
    go(417); chk("thru_pulse_early", reed_pulse, 0);
    go(418); chk("thru_pulse", reed_pulse, 1);
    go(419); chk("thru_stopped", stopped, 0); chk("thru_no_pv", period_valid, 0);
    go(430); chk("thru_npulse", npulse, 6); chk("thru_npv", npv, 3); chk("no_consec", consec, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
